// File: rtl/logic_unit_sched.sv
// Round-robin scheduler that shares one two-stage OR/XOR unit (f = a|b, g = f^b)
// between NREQ requesters and returns f, g and the winner ID over valid/ready.
module logic_unit_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_f,
  output logic [W-1:0]      res_g
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S2   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [W-1:0]    f_q, f_d, g_q, g_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            res_valid_q, res_valid_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [W-1:0]    res_f_q, res_f_d, res_g_q, res_g_d;

  logic [IDW-1:0]  winner, hi_idx, lo_idx;
  logic            hi_found;
  logic [W-1:0]    win_a, win_b;

  // Circular search: lowest set bit at or above ptr, else lowest set bit overall.
  // Scanning downward lets the last hit in each category be the lowest index.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          hi_idx   = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        win_a = a_in[i*W +: W];
        win_b = b_in[i*W +: W];
      end
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case statement can leave a signal unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    f_d         = f_q;
    g_d         = g_q;
    gnt_d       = gnt_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_f_d     = res_f_q;
    res_g_d     = res_g_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          op_a_d  = win_a;
          op_b_d  = win_b;
          op_id_d = winner;
          gnt_d   = NREQ'(1) << winner;
          ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
          state_d = S1;
        end
      end
      S1: begin
        f_d     = op_a_q | op_b_q;
        gnt_d   = '0;
        state_d = S2;
      end
      S2: begin
        g_d         = f_q ^ op_b_q;
        res_valid_d = 1'b1;
        res_f_d     = f_q;
        res_g_d     = f_q ^ op_b_q;
        res_id_d    = op_id_q;
        state_d     = DONE;
      end
      DONE: begin
        // Result fields are left untouched so they persist after the handshake.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      f_q         <= '0;
      g_q         <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_f_q     <= '0;
      res_g_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      f_q         <= f_d;
      g_q         <= g_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_f_q     <= res_f_d;
      res_g_q     <= res_g_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_f     = res_f_q;
  assign res_g     = res_g_q;

endmodule

// File: tb/tb_logic_unit_sched.sv
// Directed bench for logic_unit_sched: transaction-level reference model compared
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_logic_unit_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic              res_ready = 1'b0;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_f;
  logic [W-1:0]      res_g;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic_unit_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_f(res_f), .res_g(res_g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an operation is "active" from its grant until the result
  // is taken; its age counts cycles since the grant edge.
  int           m_ptr = 0;
  bit           m_active = 0;
  int           m_age = 0;
  int           m_id = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_valid = 0;
  logic [W-1:0] m_f = '0, m_g = '0;
  int           m_rid = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (((32'(r) >> idx) & 32'd1) != 0) return idx;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_active <= 0; m_age <= 0; m_id <= 0;
      m_a <= '0; m_b <= '0; m_valid <= 0; m_f <= '0; m_g <= '0; m_rid <= 0;
    end else if (!m_active) begin
      if (req != 0) begin
        m_id     <= pick(req, m_ptr);
        m_a      <= W'(a_in >> (pick(req, m_ptr) * W));
        m_b      <= W'(b_in >> (pick(req, m_ptr) * W));
        m_ptr    <= (pick(req, m_ptr) + 1) % NREQ;
        m_active <= 1;
        m_age    <= 0;
      end
    end else if (m_age < 2) begin
      m_age <= m_age + 1;
      if (m_age == 1) begin
        m_valid <= 1;
        m_f     <= m_a | m_b;
        m_g     <= (m_a | m_b) ^ m_b;
        m_rid   <= m_id;
      end
    end else if (res_ready) begin
      m_valid  <= 0;
      m_active <= 0;
    end
  end

  always @(negedge clk) begin
    check("gnt",       64'(gnt),       64'((m_active && m_age == 0) ? (1 << m_id) : 0));
    check("busy",      64'(busy),      64'(m_active));
    check("res_valid", 64'(res_valid), 64'(m_valid));
    check("res_id",    64'(res_id),    64'(m_rid));
    check("res_f",     64'(res_f),     64'(m_f));
    check("res_g",     64'(res_g),     64'(m_g));
  end

  task automatic wait_gnt(output logic [NREQ-1:0] g, output int t);
    g = '0;
    t = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        t = cyc;
        return;
      end
    end
    check("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int t);
    t = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid) begin
        t = cyc;
        return;
      end
    end
    check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 64'd0, 64'd1);
  endtask

  logic [NREQ-1:0] g;
  int              tg, tv, tprev;
  logic [NREQ-1:0] exp_order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    // Reset state
    #3;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request: 0x0F | 0xF0 = 0xFF, 0xFF ^ 0xF0 = 0x0F
    req = 4'b0001; a_in = 32'h0000000F; b_in = 32'h000000F0; res_ready = 1'b1;
    wait_gnt(g, tg);
    check("single_gnt", 64'(g), 64'h1);
    req = '0;
    @(negedge clk);
    check("gnt_pulse", 64'(gnt), 64'd0);
    wait_valid(tv);
    check("latency", 64'(tv - tg), 64'd2);
    check("single_f", 64'(res_f), 64'hFF);
    check("single_g", 64'(res_g), 64'h0F);
    check("single_id", 64'(res_id), 64'd0);
    wait_idle();

    // Fairness from ptr=0 with all requests held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF; a_in = 32'h44332211; b_in = 32'h88776655;
    tprev = 0;
    for (int i = 0; i < 6; i++) begin
      wait_gnt(g, tg);
      check("fair_order", 64'(g), 64'(exp_order[i]));
      if (i > 0) check("fair_spacing", 64'(tg - tprev), 64'd4);
      tprev = tg;
    end
    req = '0;
    wait_idle();

    // Back-pressure: 0x3C | 0x55 = 0x7D, 0x7D ^ 0x55 = 0x28
    res_ready = 1'b0;
    req = 4'b0100; a_in = 32'h003C0000; b_in = 32'h00550000;
    wait_gnt(g, tg);
    req = '0;
    wait_valid(tv);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_f", 64'(res_f), 64'h7D);
      check("bp_g", 64'(res_g), 64'h28);
      check("bp_id", 64'(res_id), 64'd2);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", 64'(busy), 64'd0);
    check("bp_drop", 64'(res_valid), 64'd0);
    check("bp_hold_f", 64'(res_f), 64'h7D);

    // Operand isolation: 0xAA | 0x0C = 0xAE, 0xAE ^ 0x0C = 0xA2
    req = 4'b1000; a_in = 32'hAA000000; b_in = 32'h0C000000;
    wait_gnt(g, tg);
    a_in = $urandom; b_in = $urandom; req = 4'hF;
    @(negedge clk);
    a_in = $urandom; b_in = $urandom; req = 4'h5;
    wait_valid(tv);
    req = '0;
    check("iso_f", 64'(res_f), 64'hAE);
    check("iso_g", 64'(res_g), 64'hA2);
    check("iso_id", 64'(res_id), 64'd3);
    wait_idle();

    // Wrap: grant to 3, then req=1001 must go to 0
    req = 4'b1000; a_in = 32'h01020304; b_in = 32'h10203040;
    wait_gnt(g, tg);
    check("wrap_g3", 64'(g), 64'h8);
    req = 4'b1001;
    wait_gnt(g, tg);
    check("wrap_g0", 64'(g), 64'h1);
    req = '0;
    wait_idle();

    // Asynchronous reset during S2
    req = 4'b0001; a_in = 32'h00000055; b_in = 32'h000000AA;
    wait_gnt(g, tg);
    req = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", 64'(gnt), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_f", 64'(res_f), 64'd0);
    check("arst_g", 64'(res_g), 64'd0);
    check("arst_id", 64'(res_id), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0010;
    wait_gnt(g, tg);
    check("arst_regrant", 64'(g), 64'h2);
    req = '0;
    wait_valid(tv);
    check("arst_no_stale", 64'(res_id), 64'd1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
